// File: rtl/stepper_sequencer_pkg.sv
// Shared definitions for the stepper sequencer and the downstream coil decoder.
// Holds the phase codes carried on `stat`, the sequencer state encoding and
// the phase-advance helper.
package stepper_sequencer_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef logic [PHASE_W-1:0] phase_t;

  // Phase codes; the coil decoder decodes these same values.
  localparam phase_t PH_OFF = 3'd0;
  localparam phase_t PH_A   = 3'd1;
  localparam phase_t PH_B   = 3'd2;
  localparam phase_t PH_C   = 3'd3;
  localparam phase_t PH_D   = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One full-step move in the requested direction, wrapping between D and A.
  function automatic phase_t next_phase(input phase_t ph, input logic fwd);
    phase_t nxt;
    if (fwd) begin
      nxt = (ph == PH_D) ? PH_A : phase_t'(ph + 3'd1);
    end else begin
      nxt = (ph == PH_A) ? PH_D : phase_t'(ph - 3'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stepper_sequencer_if.sv
// Motion-command channel into the stepper sequencer.
// Signals: cmd_valid/cmd_ready handshake, cmd_steps (phase steps to issue),
// cmd_dir (1 = forward), period (clk cycles per step).
// master = command source, slave = sequencer.
interface stepper_sequencer_if #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned STEP_WIDTH = 16
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [STEP_WIDTH-1:0] cmd_steps;
  logic                  cmd_dir;
  logic [DIV_WIDTH-1:0]  period;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  period,
    output cmd_ready
  );

endinterface

// File: rtl/stepper_sequencer_step_timer.sv
// Step-period timer: loadable down-counter that reloads itself on terminal count.
// Ports: clk, rst (async, active-high); load captures max(period,1)-1 as both
// the count and the reload value; en lets the counter run; tc_c is high while
// the count is zero (a step edge when en is high).
module stepper_sequencer_step_timer #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tc_c
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] reload;
  logic [DIV_WIDTH-1:0] load_val;

  // A zero period behaves as one cycle per step.
  assign load_val = (period == '0) ? '0 : period - DIV_WIDTH'(1);

  assign tc_c = (count == '0);

  // Count down to zero, then reload for the next step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= load_val;
      reload <= load_val;
    end else if (en) begin
      if (count == '0) begin
        count <= reload;
      end else begin
        count <= count - DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper phase sequencer: accepts step commands and walks the full-step
// phase A..D at a programmable period, feeding the coil decoder.
// Ports: clk, rst (async, active-high); cmd (slave command channel);
// hold keeps coils energized when idle; abort stops a move at the next edge;
// stat is the phase code to the decoder; busy marks a move in progress;
// done pulses for one cycle on normal completion.
module stepper_sequencer
  import stepper_sequencer_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  stepper_sequencer_if.slave  cmd,
  input  logic                hold,
  input  logic                abort,
  output phase_t              stat,
  output logic                busy,
  output logic                done
);

  state_t                state;
  phase_t                phase;
  logic                  dir;
  logic [STEP_WIDTH-1:0] remaining;
  logic                  tick;
  logic                  accept;
  logic                  timer_load;
  logic                  timer_en;

  assign accept     = (state == ST_IDLE) && cmd.cmd_valid;
  // A zero-step command never enters RUN, so the timer is left alone.
  assign timer_load = accept && (cmd.cmd_steps != '0);
  assign timer_en   = (state == ST_RUN) && !abort;

  stepper_sequencer_step_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .period (cmd.period),
    .tc_c   (tick)
  );

  assign cmd.cmd_ready = (state == ST_IDLE);

  // Coils are always driven in RUN; in IDLE they follow hold directly.
  assign stat = ((state == ST_RUN) || hold) ? phase : PH_OFF;

  // Move control; phase survives across commands so position is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_A;
      dir       <= 1'b0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir       <= cmd.cmd_dir;
            remaining <= cmd.cmd_steps;
            if (cmd.cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a step on the same edge.
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            phase     <= next_phase(phase, dir);
            remaining <= remaining - STEP_WIDTH'(1);
            if (remaining == STEP_WIDTH'(1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
